// File: rtl/choice_predictor_pkg.sv
// choice_predictor_pkg: package bp_choice_pkg, shared counter and pending-entry types
// for the tournament choice predictor.
package bp_choice_pkg;
   localparam int CTR_BITS = 2;
   localparam int PKG_GHR_BITS = 12;
   typedef logic [CTR_BITS-1:0] ctr_t;
   localparam ctr_t CTR_INIT = 2'b01;
   localparam ctr_t CTR_MAX = 2'b11;
   typedef struct packed {
      logic [PKG_GHR_BITS-1:0] index;
      logic                    local_pred;
      logic                    global_pred;
      logic                    final_pred;
   } pend_entry_t;
endpackage

// File: rtl/choice_predictor_if.sv
// choice_predictor_if: prediction, resolve and status signals of the choice predictor.
// CHOICE_STATS_EN adds the statistics counters.
interface choice_predictor_if #(parameter int GHR_BITS = 12);
   logic                pred_valid, local_pred, global_pred, pred_ready;
   logic                final_valid, final_pred;
   logic                resolve_valid, resolve_taken, err_underflow;
   logic [GHR_BITS-1:0] ghr;
`ifdef CHOICE_STATS_EN
   logic [15:0]         stat_global_sel, stat_mispredict;
   modport master (output pred_valid, local_pred, global_pred, resolve_valid, resolve_taken,
                   input pred_ready, final_valid, final_pred, ghr, err_underflow,
                   stat_global_sel, stat_mispredict);
   modport slave (input pred_valid, local_pred, global_pred, resolve_valid, resolve_taken,
                  output pred_ready, final_valid, final_pred, ghr, err_underflow,
                  stat_global_sel, stat_mispredict);
`else
   modport master (output pred_valid, local_pred, global_pred, resolve_valid, resolve_taken,
                   input pred_ready, final_valid, final_pred, ghr, err_underflow);
   modport slave (input pred_valid, local_pred, global_pred, resolve_valid, resolve_taken,
                  output pred_ready, final_valid, final_pred, ghr, err_underflow);
`endif
endinterface

// File: rtl/choice_predictor_fifo.sv
// choice_pending_fifo: in-order queue of unresolved predictions; push/pop are
// ignored when full/empty respectively.
module choice_pending_fifo
   import bp_choice_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        push_i,
   input  pend_entry_t din_i,
   input  logic        pop_i,
   output pend_entry_t dout_o,
   output logic        full_o,
   output logic        empty_o
);
   localparam int AW = $clog2(DEPTH);
   pend_entry_t   mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign dout_o  = mem_q[rd_q];
   always_ff @(posedge clock)
      if (do_push) mem_q[wr_q] <= din_i;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_q + AW'(do_push);
         rd_q  <= rd_q + AW'(do_pop);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/choice_predictor.sv
// choice_predictor: tournament chooser selecting local vs global prediction through a
// GHR-indexed saturating choice table, trained in order on resolve. Option: CHOICE_STATS_EN.
module choice_predictor
   import bp_choice_pkg::*;
#(
   parameter int GHR_BITS   = PKG_GHR_BITS,
   parameter int FIFO_DEPTH = 4
) (
   input logic               clock,
   input logic               reset,
   choice_predictor_if.slave bus
);
   localparam int ENTRIES = 2**GHR_BITS;
   ctr_t                cpt_q [ENTRIES];
   logic [GHR_BITS-1:0] ghr_q, ghr_d;
   logic                final_valid_q, final_pred_q, err_q, err_d;
   logic                full, empty, accept, pop, sel, up, train;
   ctr_t                ctr_rd, ctr_old, ctr_d;
   pend_entry_t         push_e, head;
   assign accept  = bus.pred_valid & ~full;
   assign pop     = bus.resolve_valid & ~empty;
   assign ctr_rd  = cpt_q[ghr_q];
   assign sel     = ctr_rd[CTR_BITS-1] ? bus.global_pred : bus.local_pred;
   assign push_e  = '{index: ghr_q, local_pred: bus.local_pred, global_pred: bus.global_pred, final_pred: sel};
   // Only disagreeing entries train; the winner is whichever matched the outcome
   assign train   = pop & (head.local_pred != head.global_pred);
   assign ctr_old = cpt_q[head.index];
   assign up      = head.global_pred == bus.resolve_taken;
   assign ctr_d   = up ? (ctr_old == CTR_MAX ? ctr_old : ctr_old + ctr_t'(1))
                       : (ctr_old == '0 ? ctr_old : ctr_old - ctr_t'(1));
   assign ghr_d   = pop ? {ghr_q[GHR_BITS-2:0], bus.resolve_taken} : ghr_q;
   assign err_d   = err_q | (bus.resolve_valid & empty);
   choice_pending_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (accept),
      .din_i   (push_e),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) cpt_q[i] <= CTR_INIT;
         ghr_q         <= '0;
         err_q         <= 1'b0;
         final_valid_q <= 1'b0;
         final_pred_q  <= 1'b0;
      end else begin
         if (train) cpt_q[head.index] <= ctr_d;
         ghr_q         <= ghr_d;
         err_q         <= err_d;
         final_valid_q <= accept;
         if (accept) final_pred_q <= sel;
      end
   assign bus.pred_ready    = ~full;
   assign bus.final_valid   = final_valid_q;
   assign bus.final_pred    = final_pred_q;
   assign bus.ghr           = ghr_q;
   assign bus.err_underflow = err_q;
`ifdef CHOICE_STATS_EN
   logic [15:0] gsel_q, misp_q;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         gsel_q <= '0;
         misp_q <= '0;
      end else begin
         if (accept && ctr_rd[CTR_BITS-1] && gsel_q != 16'hFFFF) gsel_q <= gsel_q + 16'd1;
         if (pop && head.final_pred != bus.resolve_taken && misp_q != 16'hFFFF) misp_q <= misp_q + 16'd1;
      end
   assign bus.stat_global_sel = gsel_q;
   assign bus.stat_mispredict = misp_q;
`else
   logic unused_final;
   assign unused_final = head.final_pred;
`endif
endmodule

// File: tb/tb_choice_predictor.sv
// tb_choice_predictor: directed stimulus with a final_pred scoreboard checked by a
// negedge monitor, plus direct status checks.
module tb_choice_predictor;
   logic clock = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic sb[$];
   choice_predictor_if #(.GHR_BITS(12)) bus();
   choice_predictor #(.GHR_BITS(12), .FIFO_DEPTH(4)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask
   task automatic cyc(input logic pv, input logic l, input logic g, input logic rv, input logic rt);
      bus.pred_valid    = pv;
      bus.local_pred    = l;
      bus.global_pred   = g;
      bus.resolve_valid = rv;
      bus.resolve_taken = rt;
      @(posedge clock);
      #1;
      bus.pred_valid    = 1'b0;
      bus.resolve_valid = 1'b0;
   endtask
   task automatic acc(input logic l, input logic g, input logic e);
      sb.push_back(e);
      cyc(1'b1, l, g, 1'b0, 1'b0);
   endtask
   task automatic res(input logic t);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, t);
   endtask
   always @(negedge clock)
      if (reset === 1'b1 && bus.final_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL final_unexpected: got final_valid=1 required no output");
         end else chk("final_pred", 32'(bus.final_pred), 32'(sb.pop_front()));
      end
   initial begin
      reset = 1'b0;
      bus.pred_valid = 1'b0; bus.local_pred = 1'b0; bus.global_pred = 1'b0;
      bus.resolve_valid = 1'b0; bus.resolve_taken = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_ready", 32'(bus.pred_ready), 1);
      chk("rst_ghr", 32'(bus.ghr), 0);
      chk("rst_err", 32'(bus.err_underflow), 0);
      chk("rst_valid", 32'(bus.final_valid), 0);
      reset = 1'b1;
      acc(1, 0, 1);
      chk("ready_one", 32'(bus.pred_ready), 1);
      res(0);
      acc(1, 0, 0); res(0);
      acc(1, 0, 0); res(0);
      acc(1, 0, 0); res(0);
      acc(1, 1, 1); res(0);
      acc(1, 1, 1); res(0);
      acc(1, 0, 0); res(0);
      acc(0, 1, 1); res(0);
      acc(0, 1, 1);
      sb.push_back(1'b1);
      cyc(1, 0, 1, 1, 0);
      acc(0, 1, 0);
      res(1); res(1);
      chk("ghr_train", 32'(bus.ghr), 32'h3);
      repeat (4) acc(0, 1, 0);
      chk("full_ready", 32'(bus.pred_ready), 0);
      cyc(1, 0, 1, 0, 0);
      chk("full_hold", 32'(bus.pred_ready), 0);
      cyc(1, 0, 1, 1, 0);
      chk("pop_ready", 32'(bus.pred_ready), 1);
      chk("pop_ghr", 32'(bus.ghr), 32'h6);
      repeat (3) res(0);
      chk("drain_ghr", 32'(bus.ghr), 32'h30);
      chk("drain_err", 32'(bus.err_underflow), 0);
      res(1);
      chk("uflow_err", 32'(bus.err_underflow), 1);
      chk("uflow_ghr", 32'(bus.ghr), 32'h30);
      cyc(0, 0, 0, 0, 0);
      chk("uflow_sticky", 32'(bus.err_underflow), 1);
      acc(1, 0, 1); acc(1, 0, 1);
      cyc(0, 0, 0, 0, 0);
      reset = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(bus.pred_ready), 1);
      chk("mid_rst_ghr", 32'(bus.ghr), 0);
      chk("mid_rst_err", 32'(bus.err_underflow), 0);
      chk("mid_rst_valid", 32'(bus.final_valid), 0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      res(1);
      chk("post_rst_empty", 32'(bus.err_underflow), 1);
      chk("post_rst_ghr", 32'(bus.ghr), 0);
      reset = 1'b0;
      #2;
      reset = 1'b1;
      chk("rst2_err", 32'(bus.err_underflow), 0);
      acc(1, 1, 1); acc(1, 1, 1); acc(1, 1, 1);
      res(1); res(0); res(1);
      chk("ghr_101", 32'(bus.ghr), 32'h005);
      acc(1, 0, 1); res(0);
      chk("ghr_shift", 32'(bus.ghr), 32'h00a);
`ifdef CHOICE_STATS_EN
      reset = 1'b0;
      #2;
      reset = 1'b1;
      acc(1, 0, 1); res(0);
      repeat (3) acc(1, 0, 0);
      res(0); res(0); res(1);
      chk("stat_global_sel", 32'(bus.stat_global_sel), 3);
      chk("stat_mispredict", 32'(bus.stat_mispredict), 2);
`endif
      cyc(0, 0, 0, 0, 0);
      chk("sb_drained", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/choice_predictor.md
Name: choice_predictor

Overview:
- Tournament chooser stage, directly downstream of the local and global predictors.
- Each cycle it takes their two taken/not-taken predictions and selects one via a 2-bit choice counter indexed by the global history register (GHR).
- Holds in-flight predictions in a small pending FIFO and trains the choice table and GHR when the branch outcome resolves, in order.

Parameters:
- GHR_BITS, 12, global history width; choice table has 2**GHR_BITS entries.
- CTR_BITS, 2, choice counter width (saturating).
- FIFO_DEPTH, 4, max unresolved predictions in flight (power of 2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- pred_valid  in  1  local_pred/global_pred valid this cycle.
- local_pred  in  1  local predictor taken prediction.
- global_pred  in  1  global predictor taken prediction.
- pred_ready  out  1  pending FIFO not full; a prediction is accepted only when pred_valid&pred_ready.
- final_valid  out  1  final_pred valid (one-cycle pulse).
- final_pred  out  1  selected prediction.
- resolve_valid  in  1  oldest in-flight branch resolved this cycle.
- resolve_taken  in  1  actual outcome of that branch.
- ghr  out  GHR_BITS  current committed global history, fed to the global predictor.
- err_underflow  out  1  sticky: resolve_valid seen with FIFO empty.

Behaviour:
- Reset values:
  - all choice counters = 2'b01 (weakly prefer local).
  - GHR = 0, FIFO empty, final_valid = 0, final_pred = 0, pred_ready = 1, err_underflow = 0.
- Reset asserted mid-operation clears all state immediately, including in-flight entries; no training occurs from discarded entries.
- Accept (pred_valid&pred_ready) in cycle N:
  - read ctr = CPT[ghr].
  - in cycle N+1: final_valid = 1 and final_pred = ctr[MSB] ? global_pred : local_pred.
  - push {index = ghr, local_pred, global_pred, final_pred} into the FIFO.
- Latency is exactly 1 cycle. Back-to-back accepts give back-to-back final_valid pulses.
- pred_ready = !full. There is no same-cycle bypass: when full, a push is refused even if a pop happens that cycle.
- Resolve (resolve_valid with FIFO non-empty):
  - pop the head entry.
  - if local != global: when global == resolve_taken, CPT[index] increments, saturating at 2'b11; otherwise it decrements, saturating at 2'b00.
  - if local == global: the counter is unchanged.
  - GHR <= {GHR[GHR_BITS-2:0], resolve_taken}.
- Resolve with FIFO empty: no pop, no table or GHR change; err_underflow set, cleared only by reset.
- Simultaneous accept and resolve:
  - both proceed.
  - the accept indexes with the pre-update GHR.
  - if the read and write hit the same entry, the read returns the pre-update counter value (read-old).
- The GHR is non-speculative: it updates only on resolve, never on accept.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is tracked in log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: CHOICE_STATS_EN.
- Defined: adds outputs stat_global_sel[15:0] and stat_mispredict[15:0].
  - stat_global_sel increments once per accept whose selected source is global.
  - stat_mispredict increments once per resolve where the stored final_pred != resolve_taken.
  - both saturate at 16'hFFFF and reset to 0.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package bp_choice_pkg holds:
  - typedef ctr_t (CTR_BITS-wide logic).
  - constants CTR_INIT = 2'b01 and CTR_MAX = 2'b11.
  - struct pend_entry_t {index, local_pred, global_pred, final_pred}.
- One sub-module: choice_pending_fifo. It is a parameterized synchronous FIFO of pend_entry_t with full/empty outputs and an asynchronous active-low reset.
- The table, selection, and GHR logic stay in choice_predictor.

Test Plan:
- Reset release, then accept local=1, global=0 at ghr=0 -> next cycle final_valid=1, final_pred=1 (ctr 01 selects local); pred_ready=1.
- Train global: 2 accept+resolve pairs with local=0, global=1, taken=1, GHR held by resolving with taken=0 between pairs as needed. Result: CPT[idx] goes 01->10->11 and the next accept at that index gives final_pred = global; a 3rd win stays at 11.
- Fill: 4 accepts with no resolve -> pred_ready=0. A 5th pred_valid is not accepted and gives no final_valid. One resolve gives pred_ready=1 next cycle.
- GHR: resolve sequence taken=1,0,1 from reset -> ghr = 12'h005. Agreeing predictions (local=global) leave CPT unchanged.
- resolve_valid with FIFO empty -> err_underflow=1 and stays 1, GHR unchanged. Asserting reset low mid-stream (FIFO holding 2 entries) -> FIFO empty, ghr=0, err_underflow=0.
- With CHOICE_STATS_EN defined: 3 global-selected accepts, one of which then mispredicts -> stat_global_sel=3, stat_mispredict=1.
